serial_subtractor: RTL

Bit-serial two's-complement subtractor computing `a - b - bin` over `DATA_WIDTH` cycles, LSB first, with a single registered borrow.
- Built around one combinational full-subtractor cell, the inverse counterpart of the team's full adder.
- Handshakes operands in and results out with valid/ready on both sides.
- Serves as the area-minimal subtract path for datapaths that can tolerate multi-cycle latency.

---
 rtl/serial_subtractor_pkg.sv | 20 ++
 rtl/serial_subtractor_if.sv | 48 ++++
 rtl/serial_subtractor_full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Purpose  : Shared types and constants for the bit-serial subtractor.
//            sub_state_t       - control FSM encoding (IDLE, RUN, DONE)
//            SUB_DEFAULT_WIDTH - default operand/result width
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  localparam int SUB_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Operand/result handshake bundle for serial_subtractor.
//            Input side : in_valid, in_ready, a, b, bin
//            Output side: out_valid, out_ready, diff, bout, ovf
//            slave  modport - subtractor view
//            master modport - upstream/downstream view
//            ovf exists only when SERIAL_SUB_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int DATA_WIDTH = SUB_DEFAULT_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] diff;
  logic                  bout;
`ifdef SERIAL_SUB_OVF_EN
  logic                  ovf;
`endif

  modport slave (
    input  in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, bout
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, bout
  );

endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Purpose  : One-bit combinational full subtractor, d = x - y - bin.
//            x, y, bin : minuend bit, subtrahend bit, borrow-in
//            d, bout   : difference bit, borrow-out
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  wire logic x,
  input  wire logic y,
  input  wire logic bin,
  output logic      d,
  output logic      bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when x is 0 and y is 1, or when x equals y and a borrow arrives.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial two's-complement subtractor, diff = a - b - bin,
//            processed LSB first over DATA_WIDTH cycles with one borrow flop.
//            clk   - rising-edge clock
//            reset - asynchronous active-high reset
//            bus   - serial_subtractor_if.slave (operand and result
//                    valid/ready handshakes, a, b, bin, diff, bout[, ovf])
//            Macro SERIAL_SUB_OVF_EN adds the signed-overflow output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int DATA_WIDTH = SUB_DEFAULT_WIDTH
) (
  input  wire logic           clk,
  input  wire logic           reset,
  serial_subtractor_if.slave  bus
);

  localparam int                 CNT_W  = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]   C_ONE  = CNT_W'(1);

  sub_state_t            r_state;
  sub_state_t            w_state_nxt;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_in_ready;
  logic                  w_out_valid;

  logic [DATA_WIDTH-1:0] r_a_sh;
  logic [DATA_WIDTH-1:0] r_b_sh;
  logic [DATA_WIDTH-1:0] r_diff;
  logic                  r_br;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_d;
  logic                  w_br_nxt;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs depend on the registered state only.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_shift = 1'b1;
        if (r_cnt == C_LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Serial bit slice
  // --------------------------------------------------------------------------
  full_subtractor u_fs (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_br_nxt)
  );

  // Result bits enter at the MSB so that after DATA_WIDTH shifts the first
  // (LSB) difference bit has arrived at bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_diff <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_a_sh <= bus.a;
      r_b_sh <= bus.b;
      r_br   <= bus.bin;
      r_cnt  <= '0;
    end else if (w_shift) begin
      r_a_sh <= {1'b0, r_a_sh[DATA_WIDTH-1:1]};
      r_b_sh <= {1'b0, r_b_sh[DATA_WIDTH-1:1]};
      r_diff <= {w_d, r_diff[DATA_WIDTH-1:1]};
      r_br   <= w_br_nxt;
      r_cnt  <= r_cnt + C_ONE;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_br;

`ifdef SERIAL_SUB_OVF_EN
  // Operand signs are captured at load because the shift registers lose
  // them as the operation proceeds.
  logic r_a_sign;
  logic r_b_sign;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sign <= 1'b0;
      r_b_sign <= 1'b0;
    end else if (w_load) begin
      r_a_sign <= bus.a[DATA_WIDTH-1];
      r_b_sign <= bus.b[DATA_WIDTH-1];
    end
  end

  // Overflow only possible when operand signs differ; it occurred when the
  // result sign disagrees with the minuend sign.
  assign bus.ovf = (r_a_sign != r_b_sign) && (r_diff[DATA_WIDTH-1] != r_a_sign);
`endif

endmodule : serial_subtractor
`default_nettype wire
